decoder_pipe: RTL and testbench

DECODER_PIPE -- requirements
Module: decoder_pipe

---
 rtl/decoder_pipe.sv | 166 ++++++++++++++++
 tb/tb_decoder_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered one-hot decoder with a valid/ready handshake on both sides.
//
// Each accepted select produces one registered result one cycle later:
//   - out_onehot has bit in_sel set when in_en=1 and in_sel < NUM_OUT, otherwise it is all zero.
//   - out_err is set when in_en=1 and in_sel >= NUM_OUT.
// A result is held stable while the consumer stalls. A new request can be accepted in the
// same cycle that the current result is consumed, so there is no bubble between results.
//
// Optional feature (enabled by defining DECODER_PIPE_SCAN_CLEAR_EN):
//   A clear_req pulse in IDLE starts a clear walk. The walk emits one-hot vectors for
//   indices 0..NUM_OUT-1, in order, through the same output register and stall rules.
//   While the walk runs, busy is high and in_ready is low.
//   With the macro undefined, clear_req is ignored and busy is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   request present       in_ready   request accepted on in_valid && in_ready
//   in_sel     index to decode       in_en      decode enable (0 -> all-zero vector)
//   out_valid  result valid          out_ready  consumer accepts on out_valid && out_ready
//   out_onehot decoded vector        out_err    enabled select was out of range
//   clear_req  start a clear walk    busy       clear walk in progress
module decoder_pipe #(
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned NUM_OUT = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic               out_err,
  input  logic               clear_req,
  output logic               busy
);

  // One extra bit so NUM_OUT itself (up to 2**SEL_W) is representable.
  localparam logic [SEL_W:0] NumOutW = (SEL_W+1)'(NUM_OUT);

  // Out-of-range indices decode to all zeros because no output bit matches them.
  function automatic logic [NUM_OUT-1:0] decode(input logic [SEL_W:0] idx);
    logic [NUM_OUT-1:0] res;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      res[i] = (idx == (SEL_W+1)'(i));
    end
    return res;
  endfunction

  logic               out_valid_q, out_valid_d;
  logic [NUM_OUT-1:0] onehot_q, onehot_d;
  logic               err_q, err_d;

  logic               slot_free;
  logic               accept;
  logic [SEL_W:0]     sel_ext;
  logic               sel_in_range;

  // The output register can take new data when it is empty or is being drained this cycle.
  assign slot_free    = !out_valid_q || out_ready;
  assign sel_ext      = {1'b0, in_sel};
  assign sel_in_range = sel_ext < NumOutW;
  assign accept       = in_valid && in_ready;

`ifdef DECODER_PIPE_SCAN_CLEAR_EN
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StScan = 1'b1;
  localparam logic [SEL_W:0] IdxOne = (SEL_W+1)'(1);

  logic [0:0]     state_q, state_d;
  logic [SEL_W:0] scan_idx_q, scan_idx_d;
  logic           scan_load;
  logic           walk_done;

  // Clear wins over a simultaneous request, so the request stays pending.
  assign in_ready  = reset_n && slot_free && (state_q == StIdle) && !clear_req;
  assign scan_load = (state_q == StScan) && slot_free && (scan_idx_q < NumOutW);
  // Every element has been loaded and the last one leaves the register now.
  assign walk_done = (state_q == StScan) && (scan_idx_q == NumOutW) && out_valid_q && out_ready;
  assign busy      = (state_q == StScan);

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d    = StScan;
          scan_idx_d = '0;
        end
      end
      StScan: begin
        if (walk_done) begin
          state_d    = StIdle;
          scan_idx_d = '0;
        end else if (scan_load) begin
          scan_idx_d = scan_idx_q + IdxOne;
        end
      end
      default: begin
        state_d    = StIdle;
        scan_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      scan_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
    end
  end
`else
  logic scan_load;
  logic unused_clear_req;

  assign in_ready         = reset_n && slot_free;
  assign scan_load        = 1'b0;
  assign busy             = 1'b0;
  assign unused_clear_req = clear_req;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    onehot_d    = onehot_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      onehot_d    = in_en ? decode(sel_ext) : '0;
      err_d       = in_en && !sel_in_range;
    end else if (scan_load) begin
`ifdef DECODER_PIPE_SCAN_CLEAR_EN
      out_valid_d = 1'b1;
      onehot_d    = decode(scan_idx_q);
      err_d       = 1'b0;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      onehot_d    = '0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      onehot_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      onehot_q    <= onehot_d;
      err_q       <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = onehot_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed testbench for decoder_pipe.
// The bench uses three instances: A (SEL_W=5, NUM_OUT=32), B (SEL_W=5, NUM_OUT=24) and
// C (SEL_W=3, NUM_OUT=8, used for the clear walk).
// All instances share the clock and reset. Inputs are driven and outputs are sampled at the
// falling clock edge.
module tb_decoder_pipe;

  logic clk;
  logic reset_n;

  int n_tests;
  int n_fail;

  // Instance A
  logic        a_valid, a_ready, a_en, a_ovalid, a_ordy, a_err, a_clr, a_busy;
  logic [4:0]  a_sel;
  logic [31:0] a_onehot;
  // Instance B
  logic        b_valid, b_ready, b_en, b_ovalid, b_ordy, b_err, b_clr, b_busy;
  logic [4:0]  b_sel;
  logic [23:0] b_onehot;
  // Instance C
  logic        c_valid, c_ready, c_en, c_ovalid, c_ordy, c_err, c_clr, c_busy;
  logic [2:0]  c_sel;
  logic [7:0]  c_onehot;

  decoder_pipe #(.SEL_W(5), .NUM_OUT(32)) u_dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (a_valid),
    .in_ready   (a_ready),
    .in_sel     (a_sel),
    .in_en      (a_en),
    .out_valid  (a_ovalid),
    .out_ready  (a_ordy),
    .out_onehot (a_onehot),
    .out_err    (a_err),
    .clear_req  (a_clr),
    .busy       (a_busy)
  );

  decoder_pipe #(.SEL_W(5), .NUM_OUT(24)) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (b_valid),
    .in_ready   (b_ready),
    .in_sel     (b_sel),
    .in_en      (b_en),
    .out_valid  (b_ovalid),
    .out_ready  (b_ordy),
    .out_onehot (b_onehot),
    .out_err    (b_err),
    .clear_req  (b_clr),
    .busy       (b_busy)
  );

  decoder_pipe #(.SEL_W(3), .NUM_OUT(8)) u_dut_c (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (c_valid),
    .in_ready   (c_ready),
    .in_sel     (c_sel),
    .in_en      (c_en),
    .out_valid  (c_ovalid),
    .out_ready  (c_ordy),
    .out_onehot (c_onehot),
    .out_err    (c_err),
    .clear_req  (c_clr),
    .busy       (c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    {a_valid, a_en, a_ordy, a_clr} = '0;
    {b_valid, b_en, b_ordy, b_clr} = '0;
    {c_valid, c_en, c_ordy, c_clr} = '0;
    a_sel = '0;
    b_sel = '0;
    c_sel = '0;

    // Check the outputs while reset is held low.
    repeat (2) @(negedge clk);
    a_ordy = 1'b1;
    #1;
    check("rst_a_valid",  a_ovalid, 0);
    check("rst_a_onehot", a_onehot, 0);
    check("rst_a_err",    a_err,    0);
    check("rst_a_busy",   a_busy,   0);
    check("rst_a_ready",  a_ready,  0);
    check("rst_c_busy",   c_busy,   0);
    @(negedge clk);
    reset_n = 1'b1;

    // Stream sel=0..31 back to back; each result must appear on the next cycle.
    for (int k = 0; k < 32; k++) begin
      a_valid = 1'b1;
      a_en    = 1'b1;
      a_sel   = 5'(k);
      #1 check("stream_in_ready", a_ready, 1);
      @(negedge clk);
      check("stream_valid",  a_ovalid, 1);
      check("stream_onehot", a_onehot, 64'(1) << k);
      check("stream_err",    a_err,    0);
    end
    a_valid = 1'b0;
    @(negedge clk);
    check("drain_valid",  a_ovalid, 0);
    check("drain_onehot", a_onehot, 0);

    // With in_en=0 the result is an all-zero vector and no error.
    a_valid = 1'b1;
    a_sel   = 5'd3;
    a_en    = 1'b0;
    @(negedge clk);
    check("en0_valid",  a_ovalid, 1);
    check("en0_onehot", a_onehot, 0);
    check("en0_err",    a_err,    0);

    // Stall the consumer with sel=7 loaded, then release it.
    a_sel = 5'd7;
    a_en  = 1'b1;
    @(negedge clk);
    check("stall_load", a_onehot, 64'h80);
    a_ordy = 1'b0;
    a_sel  = 5'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_onehot", a_onehot, 64'h80);
      check("stall_valid",  a_ovalid, 1);
      check("stall_ready",  a_ready,  0);
    end
    a_ordy = 1'b1;
    #1 check("release_ready", a_ready, 1);
    @(negedge clk);
    check("release_onehot", a_onehot, 64'h200);
    a_valid = 1'b0;
    @(negedge clk);
    check("release_drain", a_ovalid, 0);

    // Range checks on the NUM_OUT=24 instance.
    b_ordy  = 1'b1;
    b_valid = 1'b1;
    b_sel   = 5'd24;
    b_en    = 1'b1;
    @(negedge clk);
    check("b24_en1_onehot", b_onehot, 0);
    check("b24_en1_err",    b_err,    1);
    b_en = 1'b0;
    @(negedge clk);
    check("b24_en0_onehot", b_onehot, 0);
    check("b24_en0_err",    b_err,    0);
    b_sel = 5'd23;
    b_en  = 1'b1;
    @(negedge clk);
    check("b23_onehot", b_onehot, 64'(1) << 23);
    check("b23_err",    b_err,    0);
    b_sel = 5'd31;
    @(negedge clk);
    check("b31_onehot", b_onehot, 0);
    check("b31_err",    b_err,    1);
    b_valid = 1'b0;

`ifdef DECODER_PIPE_SCAN_CLEAR_EN
    // Raise clear_req and in_valid together: the clear walk wins and the request waits.
    c_ordy  = 1'b1;
    c_valid = 1'b1;
    c_sel   = 3'd5;
    c_en    = 1'b1;
    c_clr   = 1'b1;
    #1 check("clr_in_ready", c_ready, 0);
    @(negedge clk);
    c_clr = 1'b0;
    check("scan_start_busy",  c_busy,   1);
    check("scan_start_valid", c_ovalid, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("scan_valid",  c_ovalid, 1);
      check("scan_onehot", c_onehot, 64'(1) << k);
      check("scan_err",    c_err,    0);
      check("scan_busy",   c_busy,   1);
      check("scan_ready",  c_ready,  0);
      // A second clear_req in the middle of the walk must be ignored.
      c_clr = (k == 3);
    end
    c_clr = 1'b0;
    @(negedge clk);
    check("scan_end_busy",  c_busy,   0);
    check("scan_end_valid", c_ovalid, 0);
    check("scan_end_ready", c_ready,  1);
    @(negedge clk);
    check("pending_onehot", c_onehot, 64'h20);
    check("pending_valid",  c_ovalid, 1);
    c_valid = 1'b0;
    @(negedge clk);
    check("pending_drain", c_ovalid, 0);

    // Assert reset while the walk sits at index 3.
    c_clr = 1'b1;
    @(negedge clk);
    c_clr = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_idx3", c_onehot, 64'h08);
    reset_n = 1'b0;
    #1;
    check("abort_valid",  c_ovalid, 0);
    check("abort_onehot", c_onehot, 0);
    check("abort_busy",   c_busy,   0);
    check("abort_err",    c_err,    0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("post_abort_valid", c_ovalid, 0);
      check("post_abort_busy",  c_busy,   0);
    end
`else
    // Without the feature, clear_req is ignored and the request is accepted normally.
    c_ordy  = 1'b1;
    c_valid = 1'b1;
    c_sel   = 3'd5;
    c_en    = 1'b1;
    c_clr   = 1'b1;
    #1 check("noscan_ready", c_ready, 1);
    @(negedge clk);
    c_clr   = 1'b0;
    c_valid = 1'b0;
    check("noscan_onehot", c_onehot, 64'h20);
    check("noscan_busy",   c_busy,   0);
    @(negedge clk);
    check("noscan_drain", c_ovalid, 0);
    check("noscan_busy2", c_busy,   0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
